// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state type, BCD digit width and digit limits
// for the stopwatch core (optional lap hold: STOPWATCH_LAP_EN).
package stopwatch_pkg;

  localparam int DIG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam logic [DIG_W-1:0] MAX_SEC_U = 4'd9;
  localparam logic [DIG_W-1:0] MAX_SEC_T = 4'd5;
  localparam logic [DIG_W-1:0] MAX_MIN_U = 4'd9;
  localparam logic [DIG_W-1:0] MAX_MIN_T = 4'd5;
  localparam logic [DIG_W-1:0] MAX_CS_U  = 4'd9;
  localparam logic [DIG_W-1:0] MAX_CS_T  = 4'd9;
  localparam logic [DIG_W-1:0] MAX_HR_U  = 4'd9;
  localparam logic [DIG_W-1:0] MAX_HR_T  = 4'd9;

  localparam logic [31:0] SAT_VAL = 32'h9959_5999;

  function automatic logic is_sat(input logic [31:0] v);
    return v == SAT_VAL;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit of the stopwatch cascade, wrapping at MAX
// and passing a carry on only when it wraps under an incoming carry.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [DIG_W-1:0] MAX = 4'd9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ci_i,
  output logic [DIG_W-1:0] val_o,
  output logic             co_o
);

  logic [DIG_W-1:0] val_q;
  logic [DIG_W-1:0] val_d;
  logic             at_max;

  // >= rather than == so an out-of-range value can only wrap to zero
  assign at_max = (val_q >= MAX);

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (ci_i) begin
      val_d = at_max ? '0 : val_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;
  assign co_o  = ci_i & at_max;

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: HH:MM:SS.cc BCD stopwatch with IDLE/RUN/PAUSE control.
// Define STOPWATCH_LAP_EN to build the lap (display freeze) hold.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_DIV = CLK_FREQ / 100
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        mode_stopwatch,
  input  logic        key_start_stop,
  input  logic        key_clear,
  input  logic        key_lap,
  output logic [31:0] data_stopwatch,
  output logic        running
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  sw_state_e     state_q;
  sw_state_e     state_d;
  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          ss_acc;
  logic          clr_acc;
  logic          tick;
  logic          sat;
  logic [31:0]   cnt;
  logic [8:0]    cy;
  logic          unused_co;

  assign ss_acc  = mode_stopwatch & key_start_stop;
  assign clr_acc = mode_stopwatch & key_clear;
  assign tick    = (state_q == ST_RUN) && (pre_q == PRE_LAST);
  assign sat     = is_sat(cnt);
  assign running = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ss_acc) state_d = ST_RUN;
      ST_RUN:   if (ss_acc || (tick && sat)) state_d = ST_PAUSE;
      ST_PAUSE: if (ss_acc) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (clr_acc) state_d = ST_IDLE;
  end

  // restart the prescaler on every RUN entry so a resume waits a full tick
  always_comb begin
    pre_d = pre_q;
    if (clr_acc || (state_d == ST_RUN && state_q != ST_RUN)) begin
      pre_d = '0;
    end else if (state_q == ST_RUN) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
    end
  end

  assign cy[0]     = tick & ~sat & ~clr_acc;
  assign unused_co = cy[8];

  bcd_digit_cnt #(.MAX(MAX_CS_U)) u_cs0 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .clr_i  (clr_acc),
    .ci_i   (cy[0]),
    .val_o  (cnt[3:0]),
    .co_o   (cy[1])
  );

  bcd_digit_cnt #(.MAX(MAX_CS_T)) u_cs1 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .clr_i  (clr_acc),
    .ci_i   (cy[1]),
    .val_o  (cnt[7:4]),
    .co_o   (cy[2])
  );

  bcd_digit_cnt #(.MAX(MAX_SEC_U)) u_s0 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .clr_i  (clr_acc),
    .ci_i   (cy[2]),
    .val_o  (cnt[11:8]),
    .co_o   (cy[3])
  );

  bcd_digit_cnt #(.MAX(MAX_SEC_T)) u_s1 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .clr_i  (clr_acc),
    .ci_i   (cy[3]),
    .val_o  (cnt[15:12]),
    .co_o   (cy[4])
  );

  bcd_digit_cnt #(.MAX(MAX_MIN_U)) u_m0 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .clr_i  (clr_acc),
    .ci_i   (cy[4]),
    .val_o  (cnt[19:16]),
    .co_o   (cy[5])
  );

  bcd_digit_cnt #(.MAX(MAX_MIN_T)) u_m1 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .clr_i  (clr_acc),
    .ci_i   (cy[5]),
    .val_o  (cnt[23:20]),
    .co_o   (cy[6])
  );

  bcd_digit_cnt #(.MAX(MAX_HR_U)) u_h0 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .clr_i  (clr_acc),
    .ci_i   (cy[6]),
    .val_o  (cnt[27:24]),
    .co_o   (cy[7])
  );

  bcd_digit_cnt #(.MAX(MAX_HR_T)) u_h1 (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .clr_i  (clr_acc),
    .ci_i   (cy[7]),
    .val_o  (cnt[31:28]),
    .co_o   (cy[8])
  );

`ifdef STOPWATCH_LAP_EN
  logic        hold_q;
  logic        hold_d;
  logic [31:0] lap_q;
  logic [31:0] lap_d;
  logic        lap_acc;

  assign lap_acc = mode_stopwatch & key_lap & ~key_clear & (state_q == ST_RUN);

  always_comb begin
    hold_d = hold_q;
    lap_d  = lap_q;
    if (clr_acc) begin
      hold_d = 1'b0;
    end else if (lap_acc) begin
      hold_d = ~hold_q;
      if (!hold_q) lap_d = cnt;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      lap_q  <= '0;
    end else begin
      hold_q <= hold_d;
      lap_q  <= lap_d;
    end
  end

  assign data_stopwatch = hold_q ? lap_q : cnt;
`else
  logic unused_lap;

  assign unused_lap     = key_lap;
  assign data_stopwatch = cnt;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: scoreboard bench for stopwatch_core at TICK_DIV=4.
// Lap checks are built when STOPWATCH_LAP_EN is defined.
`timescale 1ns/1ps
module tb_stopwatch_core;

  logic        sys_clk        = 1'b0;
  logic        rst_n          = 1'b1;
  logic        mode_stopwatch = 1'b1;
  logic        key_start_stop = 1'b0;
  logic        key_clear      = 1'b0;
  logic        key_lap        = 1'b0;
  logic [31:0] data_stopwatch;
  logic        running;
  logic [31:0] pre_v          = '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  stopwatch_core #(.TICK_DIV(4)) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .mode_stopwatch (mode_stopwatch),
    .key_start_stop (key_start_stop),
    .key_clear      (key_clear),
    .key_lap        (key_lap),
    .data_stopwatch (data_stopwatch),
    .running        (running)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got no entry, want one");
    end else begin
      e = sb.pop_front();
      chk(e.tag, data_stopwatch, e.val);
    end
  endtask

  task automatic chk_run(input string tag, input logic exp);
    chk(tag, {31'b0, running}, {31'b0, exp});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse(input logic ss, input logic clr, input logic lap);
    key_start_stop = ss;
    key_clear      = clr;
    key_lap        = lap;
    @(negedge sys_clk);
    key_start_stop = 1'b0;
    key_clear      = 1'b0;
    key_lap        = 1'b0;
  endtask

  // Digits are forced across a paused clock edge so the flops latch them.
  task automatic preload(input logic [31:0] v);
    pre_v = v;
    force dut.u_cs0.val_q = pre_v[3:0];
    force dut.u_cs1.val_q = pre_v[7:4];
    force dut.u_s0.val_q  = pre_v[11:8];
    force dut.u_s1.val_q  = pre_v[15:12];
    force dut.u_m0.val_q  = pre_v[19:16];
    force dut.u_m1.val_q  = pre_v[23:20];
    force dut.u_h0.val_q  = pre_v[27:24];
    force dut.u_h1.val_q  = pre_v[31:28];
    @(posedge sys_clk);
    @(negedge sys_clk);
    release dut.u_cs0.val_q;
    release dut.u_cs1.val_q;
    release dut.u_s0.val_q;
    release dut.u_s1.val_q;
    release dut.u_m0.val_q;
    release dut.u_m1.val_q;
    release dut.u_h0.val_q;
    release dut.u_h1.val_q;
    cyc(1);
    push("preload", v); pop_chk();
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    push("rst_data", 32'h0); pop_chk();
    chk_run("rst_run", 1'b0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    push("idle_wait", 32'h0); cyc(3); pop_chk();

    pulse(1, 0, 0);
    chk_run("start_run", 1'b1);
    push("pre_tick", 32'h0); cyc(3); pop_chk();
    push("first_tick", 32'h0000_0001); cyc(1); pop_chk();
    push("one_sec", 32'h0000_0100); cyc(396); pop_chk();

    pulse(0, 1, 0);
    push("clr", 32'h0); pop_chk();
    chk_run("clr_run", 1'b0);
    pulse(1, 0, 0);
    push("at_37", 32'h0000_0037); cyc(148); pop_chk();
    pulse(1, 0, 0);
    chk_run("paused", 1'b0);
    push("pause_hold", 32'h0000_0037); cyc(100); pop_chk();
    pulse(1, 0, 0);
    chk_run("resumed", 1'b1);
    push("resume_pre", 32'h0000_0037); cyc(3); pop_chk();
    push("resume_tick", 32'h0000_0038); cyc(1); pop_chk();
    pulse(1, 0, 0);

    mode_stopwatch = 1'b0;
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    chk_run("gate_run", 1'b0);
    push("gate_data", 32'h0000_0038); pop_chk();
    mode_stopwatch = 1'b1;
    pulse(1, 0, 0);
    mode_stopwatch = 1'b0;
    push("mode0_count", 32'h0000_0039); cyc(4); pop_chk();
    pulse(0, 1, 0);
    chk_run("mode0_clr_ign", 1'b1);
    push("mode0_clr_data", 32'h0000_0039); pop_chk();
    mode_stopwatch = 1'b1;

    pulse(1, 1, 0);
    chk_run("both_run", 1'b0);
    push("both_data", 32'h0); pop_chk();
    push("both_idle", 32'h0); cyc(8); pop_chk();
    chk_run("both_idle_run", 1'b0);

    pulse(1, 0, 0);
    pulse(1, 0, 0);
    preload(32'h0059_5999);
    pulse(1, 0, 0);
    push("carry_pre", 32'h0059_5999); cyc(3); pop_chk();
    push("carry_hr", 32'h0100_0000); cyc(1); pop_chk();
    pulse(1, 0, 0);

    preload(32'h9959_5999);
    pulse(1, 0, 0);
    chk_run("sat_run", 1'b1);
    cyc(4);
    chk_run("sat_stop", 1'b0);
    push("sat_hold", 32'h9959_5999); pop_chk();
    pulse(1, 0, 0);
    chk_run("sat_rerun", 1'b1);
    cyc(4);
    chk_run("sat_restop", 1'b0);
    push("sat_rehold", 32'h9959_5999); pop_chk();
    pulse(0, 1, 0);
    push("sat_clr", 32'h0); pop_chk();

    pulse(1, 0, 0);
    push("pre_rst", 32'h0000_0002); cyc(10); pop_chk();
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", 32'h0); pop_chk();
    chk_run("async_rst_run", 1'b0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    push("post_rst", 32'h0); cyc(10); pop_chk();
    chk_run("post_rst_run", 1'b0);
    pulse(1, 0, 0);
    push("post_rst_tick", 32'h0000_0001); cyc(4); pop_chk();
    pulse(0, 1, 0);

`ifdef STOPWATCH_LAP_EN
    pulse(1, 0, 0);
    push("lap_at_12", 32'h0000_0012); cyc(48); pop_chk();
    pulse(0, 0, 1);
    push("lap_frozen", 32'h0000_0012); cyc(50); pop_chk();
    chk_run("lap_run", 1'b1);
    cyc(21);
    pulse(0, 0, 1);
    push("lap_release", 32'h0000_0030); pop_chk();
    push("lap_live_37", 32'h0000_0037); cyc(27); pop_chk();
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    push("lap_pause_ign", 32'h0000_0038); cyc(4); pop_chk();
    pulse(0, 0, 1);
    pulse(0, 1, 0);
    push("lap_clr_rel", 32'h0); pop_chk();
`else
    pulse(1, 0, 0);
    push("nolap_pre", 32'h0000_0002); cyc(8); pop_chk();
    pulse(0, 0, 1);
    push("nolap_live", 32'h0000_0005); cyc(11); pop_chk();
    pulse(0, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_DIV, default CLK_FREQ/100, sys_clk cycles per centisecond tick.
REQ-003 SHALL have port sys_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port mode_stopwatch, input, 1; high means the stopwatch view is selected and keys are accepted.
REQ-006 SHALL have port key_start_stop, input, 1, single-cycle debounced press pulse.
REQ-007 SHALL have port key_clear, input, 1, single-cycle debounced press pulse.
REQ-008 SHALL have port key_lap, input, 1, single-cycle debounced press pulse; it is used only when the lap feature is compiled in.
REQ-009 SHALL have port data_stopwatch, output, 32, eight packed BCD digits HH:MM:SS.cc; [31:28] is hour tens and [3:0] is centisecond units; this feeds the display selector.
REQ-010 SHALL have port running, output, 1; high while the FSM is in RUN.

Function
REQ-011 SHALL implement FSM states IDLE (count zero), RUN and PAUSE.
REQ-012 SHALL ignore all key pulses while mode_stopwatch=0; counting continues regardless of mode.
REQ-013 SHALL apply these transitions:
- IDLE --start_stop--> RUN
- RUN --start_stop--> PAUSE
- PAUSE --start_stop--> RUN
- any state --clear--> IDLE
REQ-014 SHALL give key_clear priority over key_start_stop and key_lap when they occur in the same cycle; all digits zero and the state is IDLE on the next cycle.
REQ-015 SHALL assert running in the cycle after the accepted start_stop pulse.
REQ-016 SHALL reset the prescaler to 0 on every entry to RUN; the first tick occurs TICK_DIV cycles after entry; the prescaler holds in PAUSE and IDLE.
REQ-017 SHALL increment the count by 0.01 s on each tick, as a BCD cascade with these digit limits:
- cs 0-99
- sec 0-59
- min 0-59
- hour 0-99
REQ-018 SHALL carry into the next digit only when all lower digits wrap in the same tick.
REQ-019 SHALL register data_stopwatch; it reflects a tick one cycle after the tick cycle.
REQ-020 SHALL saturate at 99:59:59.99: the count holds and the FSM enters PAUSE; a later start_stop returns to RUN, but the count stays saturated until clear.
REQ-021 SHALL never hold an invalid BCD digit (value >9, or tens digit >5 for min/sec) on data_stopwatch.

Reset
REQ-022 SHALL, on rst_n low, immediately clear state to IDLE, all digits to 0, the prescaler to 0, running to 0 and the lap hold to 0, independent of sys_clk.
REQ-023 SHALL abandon any in-progress count when reset asserts mid-RUN; after release the block waits in IDLE for start_stop.

Configuration
REQ-024 SHALL support macro STOPWATCH_LAP_EN.
REQ-025 SHALL, when STOPWATCH_LAP_EN is defined:
- an accepted key_lap in RUN toggles the lap hold
- while held, data_stopwatch freezes at the value current when lap was pressed, and counting continues internally
- a second key_lap releases the hold, and data_stopwatch shows the live count on the next cycle
- key_lap in IDLE/PAUSE is ignored
- clear releases the hold
REQ-026 SHALL, when STOPWATCH_LAP_EN is undefined, ignore key_lap, create no hold register, and keep data_stopwatch always live.

Structure
REQ-027 SHALL place in a shared package stopwatch_pkg:
- the FSM state typedef (IDLE/RUN/PAUSE)
- digit-limit constants (9, 5, 9, 5, 9, 9, 9, 9)
- the BCD digit width constant 4
REQ-028 SHALL use one sub-module bcd_digit_cnt (parameter MAX; ports: carry-in, clear, value, carry-out), instantiated eight times.

Verification (TICK_DIV=4)
REQ-029 SHALL cover start: start_stop pulse -> running=1 next cycle; data_stopwatch=32'h0000_0001 4 cycles after RUN entry; 32'h0000_0100 after 400 cycles.
REQ-030 SHALL cover pause/resume: pause at 32'h0000_0037 -> value held for 100 cycles; resume -> next increment exactly 4 cycles later.
REQ-031 SHALL cover the carry chain: preload by running to 32'h0059_5999, one tick -> 32'h0100_0000; at 32'h9959_5999, one tick -> value held, running=0.
REQ-032 SHALL cover simultaneous and gated keys:
- clear+start_stop same cycle in RUN -> IDLE, 32'h0, running=0
- keys with mode_stopwatch=0 -> no state change
REQ-033 SHALL cover reset: rst_n low mid-RUN between clock edges -> outputs zero immediately; after release, idle until start_stop.
REQ-034 SHALL cover lap (STOPWATCH_LAP_EN): lap at 32'h0000_0012 -> output frozen while internal count advances; second lap -> live value 32'h0000_0037 after 100 further cycles.
